bsg_lru_pseudo_tree_manager: RTL and testbench



---
 rtl/bsg_lru_pseudo_tree_manager_pkg.sv | 15 +
 rtl/bsg_lru_pseudo_tree_encode.sv | 38 +++
 rtl/bsg_lru_pseudo_tree_update.sv | 36 +++
 rtl/bsg_lru_pseudo_tree_manager.sv | 136 +++++++++++++
 tb/tb_bsg_lru_pseudo_tree_manager.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_lru_pseudo_tree_manager_pkg.sv
// Shared types for the pseudo-tree LRU manager.
//
// Contents:
//   lru_state_e - control state of the manager: clearing the tree bits (INIT),
//                 waiting for a victim request (IDLE), or holding a victim
//                 response for the consumer (RESP).
package bsg_lru_pseudo_tree_manager_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } lru_state_e;

endpackage

// File: rtl/bsg_lru_pseudo_tree_encode.sv
// Pseudo-tree LRU victim encoder.
//
// Walks the tree from the root. At each level the current node's bit picks
// the LRU half: 0 selects the lower half, 1 the upper half. That bit becomes
// the next way bit, MSB first. The level-l node for path prefix p is
// (2^l - 1) + p.
//
// Ports:
//   lru_i  in  ways_p-1    tree bits of one set
//   way_o  out lg_ways_lp  least-recently-used way
module bsg_lru_pseudo_tree_encode #(
    parameter  int ways_p     = 8,
    localparam int lg_ways_lp = $clog2(ways_p)
) (
    input  logic [ways_p-2:0]     lru_i,
    output logic [lg_ways_lp-1:0] way_o
);

    logic [lg_ways_lp-1:0] way;
    logic [lg_ways_lp-1:0] node;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        way  = '0;
        node = '0;
        for (int l = 0; l < lg_ways_lp; l++) begin
            way[lg_ways_lp-1-l] = lru_i[node];
            // Node for the next level, indexed by the prefix decoded so far.
            // On the last level this value is computed but not used.
            node = lg_ways_lp'((1 << (l + 1)) - 1)
                 + lg_ways_lp'(way >> (lg_ways_lp - 1 - l));
        end
    end

    assign way_o = way;

endmodule

// File: rtl/bsg_lru_pseudo_tree_update.sv
// Pseudo-tree LRU update generator.
//
// Makes a way the MRU. Every node on the way's root-to-leaf path is set so
// that it points away from the way: data bit = inverse of the way bit at
// that level. Nodes off the path keep their value. The caller applies the
// update as (old & ~mask_o) | (data_o & mask_o).
//
// Ports:
//   way_i   in  lg_ways_lp  way being made most-recently-used
//   mask_o  out ways_p-1    1 on the nodes of the way's path
//   data_o  out ways_p-1    new value for the masked nodes
module bsg_lru_pseudo_tree_update #(
    parameter  int ways_p     = 8,
    localparam int lg_ways_lp = $clog2(ways_p)
) (
    input  logic [lg_ways_lp-1:0] way_i,
    output logic [ways_p-2:0]     mask_o,
    output logic [ways_p-2:0]     data_o
);

    logic [lg_ways_lp-1:0] node;

    always_comb begin
        mask_o = '0;
        data_o = '0;
        node   = '0;
        for (int l = 0; l < lg_ways_lp; l++) begin
            // The prefix at level l is made of the top l way bits.
            node = lg_ways_lp'((1 << l) - 1)
                 + lg_ways_lp'(way_i >> (lg_ways_lp - l));
            mask_o[node] = 1'b1;
            data_o[node] = ~way_i[lg_ways_lp-1-l];
        end
    end

endmodule

// File: rtl/bsg_lru_pseudo_tree_manager.sv
// Per-set pseudo-tree LRU state keeper and victim scheduler.
//
// It holds ways_p-1 tree bits per set in a flop array. It takes one hit touch
// per cycle and serves victim allocations through a valid/ready request port
// and a valid/yumi response port. After reset it clears one set per cycle for
// sets_p cycles before it accepts requests.
//
// Ports:
//   clk_i        in  clock
//   reset_i      in  synchronous active-high reset, restarts the clear
//   touch_v_i    in  hit update valid; ignored while clearing
//   touch_set_i  in  set of the hit
//   touch_way_i  in  way that hit; becomes MRU
//   v_i          in  victim request valid
//   set_i        in  set of the victim request
//   ready_o      out request accepted this cycle if v_i is high (IDLE only)
//   v_o          out victim response valid
//   set_o        out set of the pending response
//   way_o        out victim way of the pending response
//   yumi_i       in  consumer takes the response and commits the allocation
module bsg_lru_pseudo_tree_manager
    import bsg_lru_pseudo_tree_manager_pkg::*;
#(
    parameter  int ways_p     = 8,
    parameter  int sets_p     = 64,
    localparam int lg_ways_lp = $clog2(ways_p),
    localparam int lg_sets_lp = $clog2(sets_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  touch_v_i,
    input  logic [lg_sets_lp-1:0] touch_set_i,
    input  logic [lg_ways_lp-1:0] touch_way_i,

    input  logic                  v_i,
    input  logic [lg_sets_lp-1:0] set_i,
    output logic                  ready_o,

    output logic                  v_o,
    output logic [lg_sets_lp-1:0] set_o,
    output logic [lg_ways_lp-1:0] way_o,
    input  logic                  yumi_i
);

    lru_state_e state_r, state_n;

    logic [lg_sets_lp-1:0] init_cnt_r;
    logic [ways_p-2:0]     lru_r [sets_p];
    logic [ways_p-2:0]     lru_n [sets_p];

    logic                  accept;
    logic                  commit;
    logic                  touch_en;
    logic [lg_ways_lp-1:0] victim_way;
    logic [ways_p-2:0]     touch_mask, touch_data;
    logic [ways_p-2:0]     commit_mask, commit_data;

    assign ready_o  = (state_r == IDLE);
    assign v_o      = (state_r == RESP);
    assign accept   = ready_o & v_i;
    assign commit   = v_o & yumi_i;
    assign touch_en = touch_v_i & (state_r != INIT);

    // Victim comes from the registered tree bits, so a touch in the same
    // cycle as the acceptance is not seen by this victim.
    bsg_lru_pseudo_tree_encode #(.ways_p(ways_p)) victim_encode (
        .lru_i (lru_r[set_i]),
        .way_o (victim_way)
    );

    bsg_lru_pseudo_tree_update #(.ways_p(ways_p)) touch_update (
        .way_i  (touch_way_i),
        .mask_o (touch_mask),
        .data_o (touch_data)
    );

    bsg_lru_pseudo_tree_update #(.ways_p(ways_p)) commit_update (
        .way_i  (way_o),
        .mask_o (commit_mask),
        .data_o (commit_data)
    );

    // ---------------- control FSM ----------------
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            INIT:    if (init_cnt_r == lg_sets_lp'(sets_p - 1)) state_n = IDLE;
            IDLE:    if (v_i)    state_n = RESP;
            RESP:    if (yumi_i) state_n = IDLE;
            default: state_n = INIT;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples values from before the edge whatever the block order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= INIT;
            init_cnt_r <= '0;
            set_o      <= '0;
            way_o      <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == INIT) init_cnt_r <= init_cnt_r + 1'b1;
            if (accept) begin
                set_o <= set_i;
                way_o <= victim_way;
            end
        end
    end

    // ---------------- tree bit array ----------------
    // The touch is applied first and the commit on top of it, so on a
    // same-set collision the commit wins on the nodes they share.
    always_comb begin
        lru_n = lru_r;
        if (state_r == INIT) begin
            lru_n[init_cnt_r] = '0;
        end else begin
            if (touch_en)
                lru_n[touch_set_i] = (lru_n[touch_set_i] & ~touch_mask)
                                   | (touch_data & touch_mask);
            if (commit)
                lru_n[set_o] = (lru_n[set_o] & ~commit_mask)
                             | (commit_data & commit_mask);
        end
    end

    // NOTE: the array has no reset term; INIT clears it one set per cycle,
    // which keeps reset fan-out off the storage flops.
    always_ff @(posedge clk_i) begin
        lru_r <= lru_n;
    end

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_manager.sv
// Directed testbench for bsg_lru_pseudo_tree_manager (ways_p = 8, sets_p = 64).
// Expected victims are hand-derived from the tree encoding.
module tb_bsg_lru_pseudo_tree_manager;

    localparam int ways_p = 8;
    localparam int sets_p = 64;
    localparam int lg_ways_lp = 3;
    localparam int lg_sets_lp = 6;

    logic                  clk_i = 1'b0;
    logic                  reset_i = 1'b1;
    logic                  touch_v_i = 1'b0;
    logic [lg_sets_lp-1:0] touch_set_i = '0;
    logic [lg_ways_lp-1:0] touch_way_i = '0;
    logic                  v_i = 1'b0;
    logic [lg_sets_lp-1:0] set_i = '0;
    logic                  ready_o;
    logic                  v_o;
    logic [lg_sets_lp-1:0] set_o;
    logic [lg_ways_lp-1:0] way_o;
    logic                  yumi_i = 1'b0;

    int checks = 0;
    int errors = 0;

    bsg_lru_pseudo_tree_manager #(.ways_p(ways_p), .sets_p(sets_p)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .touch_v_i   (touch_v_i),
        .touch_set_i (touch_set_i),
        .touch_way_i (touch_way_i),
        .v_i         (v_i),
        .set_i       (set_i),
        .ready_o     (ready_o),
        .v_o         (v_o),
        .set_o       (set_o),
        .way_o       (way_o),
        .yumi_i      (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Releases reset and counts cycles until ready_o rises. Optionally
    // touches set 5 way 0 at cycle 10 of INIT, which must be ignored.
    task automatic wait_init(input bit touch_in_init);
        int n = 0;
        reset_i = 1'b0;
        while (!ready_o && n < 200) begin
            step();
            n++;
            touch_v_i = 1'b0;
            if (touch_in_init && n == 10) begin
                touch_v_i   = 1'b1;
                touch_set_i = 6'd5;
                touch_way_i = 3'd0;
            end
            if (n < 64) check("ready_low_in_init", int'(ready_o), 0);
        end
        touch_v_i = 1'b0;
        check("init_length", n, 64);
    endtask

    // One allocation: request set s, yumi right away. A touch of (ts, tw)
    // can ride along the acceptance cycle and/or the yumi cycle.
    task automatic alloc(input int s, input bit acc_t, input bit yumi_t,
                         input int ts, input int tw, output int way);
        int n = 0;
        while (!ready_o && n < 20) begin
            step();
            n++;
        end
        check("ready_before_req", int'(ready_o), 1);
        v_i   = 1'b1;
        set_i = 6'(s);
        if (acc_t) begin
            touch_v_i   = 1'b1;
            touch_set_i = 6'(ts);
            touch_way_i = 3'(tw);
        end
        step();
        v_i       = 1'b0;
        touch_v_i = 1'b0;
        check("v_o_after_accept", int'(v_o), 1);
        check("ready_low_in_resp", int'(ready_o), 0);
        check("set_o", int'(set_o), s);
        way    = int'(way_o);
        yumi_i = 1'b1;
        if (yumi_t) begin
            touch_v_i   = 1'b1;
            touch_set_i = 6'(ts);
            touch_way_i = 3'(tw);
        end
        step();
        yumi_i    = 1'b0;
        touch_v_i = 1'b0;
        check("v_o_after_yumi", int'(v_o), 0);
        check("ready_after_yumi", int'(ready_o), 1);
    endtask

    initial begin
        int way;
        int rot [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};

        // ---- reset values and INIT ----
        step();
        step();
        check("reset_ready", int'(ready_o), 0);
        check("reset_v_o", int'(v_o), 0);
        check("reset_set_o", int'(set_o), 0);
        check("reset_way_o", int'(way_o), 0);
        wait_init(1'b1);

        // Touch during INIT ignored: set 5 victim is way 0.
        alloc(5, 1'b0, 1'b0, 0, 0, way);
        check("init_touch_ignored", way, 0);

        // ---- touch steering ----
        touch_v_i   = 1'b1;
        touch_set_i = 6'd9;
        touch_way_i = 3'd0;
        step();
        touch_v_i = 1'b0;
        alloc(9, 1'b0, 1'b0, 0, 0, way);
        check("touch_steer_set9", way, 4);

        // ---- held response with touches of set_o way 4 ----
        v_i   = 1'b1;
        set_i = 6'd12;
        step();
        v_i = 1'b0;
        check("held_way_first", int'(way_o), 0);
        for (int i = 0; i < 5; i++) begin
            touch_v_i   = 1'b1;
            touch_set_i = 6'd12;
            touch_way_i = 3'd4;
            step();
            check("held_v_o", int'(v_o), 1);
            check("held_way_o", int'(way_o), 0);
        end
        touch_v_i = 1'b0;
        yumi_i    = 1'b1;
        step();
        yumi_i = 1'b0;
        // Touch way 4 then commit way 0 leaves nodes 0,1,2,3,5 = 1: victim 6.
        alloc(12, 1'b0, 1'b0, 0, 0, way);
        check("held_then_commit_set12", way, 6);

        // ---- touch during acceptance is not seen by that victim ----
        alloc(40, 1'b1, 1'b0, 40, 0, way);
        check("accept_touch_invisible", way, 0);
        alloc(40, 1'b0, 1'b0, 0, 0, way);
        check("accept_touch_later", way, 4);

        // ---- commit and touch to different sets ----
        alloc(30, 1'b0, 1'b1, 31, 0, way);
        check("diff_set_commit_way", way, 0);
        alloc(30, 1'b0, 1'b0, 0, 0, way);
        check("diff_set_commit_kept", way, 4);
        alloc(31, 1'b0, 1'b0, 0, 0, way);
        check("diff_set_touch_kept", way, 4);

        // ---- allocation rotation on set 3 ----
        for (int i = 0; i < 9; i++) begin
            alloc(3, 1'b0, 1'b0, 0, 0, way);
            check($sformatf("rotation_%0d", i), way, rot[i]);
        end

        // ---- reset while a response is pending ----
        v_i   = 1'b1;
        set_i = 6'd3;
        step();
        v_i = 1'b0;
        check("pending_before_reset", int'(v_o), 1);
        reset_i = 1'b1;
        step();
        check("v_o_drop_on_reset", int'(v_o), 0);
        check("ready_low_on_reset", int'(ready_o), 0);
        wait_init(1'b0);

        // ---- set 3 cleared; then same-set collision ----
        v_i   = 1'b1;
        set_i = 6'd3;
        step();
        v_i = 1'b0;
        check("after_reset_set3", int'(way_o), 0);
        yumi_i      = 1'b1;
        touch_v_i   = 1'b1;
        touch_set_i = 6'd3;
        touch_way_i = 3'd7;
        step();
        yumi_i    = 1'b0;
        touch_v_i = 1'b0;
        alloc(3, 1'b0, 1'b0, 0, 0, way);
        check("collision_commit_wins", way, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
